pipe_elastic_reg: RTL and testbench

//  Parametrised elastic pipeline register replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_types_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 28 ++
 rtl/pipe_elastic_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_elastic_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_types_pkg
//  Purpose  : Shared pipeline types: payload word, skid FSM states, NOP bubble.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } skid_state_t;

   localparam word_t NOP_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sat_counter
//  Purpose  : Saturating event counter with synchronous clear (clear wins).
//  Revision : 1.0  initial release
// ============================================================================
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_elastic_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_elastic_reg
//  Purpose  : Elastic valid/ready pipeline register with flush, NOP bubbles,
//             optional 2-entry skid buffer and a saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_elastic_reg #(
   parameter int               WIDTH  = 32,
   parameter int               SKID   = 1,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             cnt_clr
);

   import pipe_types_pkg::*;

   logic w_accept;
   logic w_pop;

   assign w_accept = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;

   generate
      if (SKID != 0) begin : g_skid
         skid_state_t      r_state, w_state_nx;
         logic [WIDTH-1:0] r_main, w_main_nx;
         logic [WIDTH-1:0] r_skid, w_skid_nx;
         logic             r_ready;

         always_comb begin
            w_state_nx = r_state;
            w_main_nx  = r_main;
            w_skid_nx  = r_skid;
            case (r_state)
               EMPTY: begin
                  if (w_accept) begin
                     w_state_nx = ONE;
                     w_main_nx  = in_data;
                  end
               end
               ONE: begin
                  if (w_accept && !w_pop) begin
                     w_state_nx = TWO;
                     w_skid_nx  = in_data;
                  end else if (w_accept && w_pop) begin
                     w_main_nx  = in_data;
                  end else if (w_pop) begin
                     w_state_nx = EMPTY;
                     w_main_nx  = BUBBLE;
                  end
               end
               TWO: begin
                  if (w_pop) begin
                     w_state_nx = ONE;
                     w_main_nx  = r_skid;
                     w_skid_nx  = BUBBLE;
                  end
               end
               default: begin
                  w_state_nx = EMPTY;
                  w_main_nx  = BUBBLE;
                  w_skid_nx  = BUBBLE;
               end
            endcase
            // Flush overrides everything; a same-cycle accept is simply dropped.
            if (flush) begin
               w_state_nx = EMPTY;
               w_main_nx  = BUBBLE;
               w_skid_nx  = BUBBLE;
            end
         end

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_state <= EMPTY;
               r_main  <= BUBBLE;
               r_skid  <= BUBBLE;
               r_ready <= 1'b1;
            end else begin
               r_state <= w_state_nx;
               r_main  <= w_main_nx;
               r_skid  <= w_skid_nx;
               r_ready <= (w_state_nx != TWO);
            end
         end

         assign in_ready  = r_ready;
         assign out_valid = (r_state != EMPTY);
         assign out_data  = r_main;
         assign occupancy = 2'(r_state);
      end else begin : g_single
         logic [WIDTH-1:0] r_main;
         logic             r_valid;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_main  <= BUBBLE;
               r_valid <= 1'b0;
            end else if (flush) begin
               r_main  <= BUBBLE;
               r_valid <= 1'b0;
            end else if (w_accept) begin
               r_main  <= in_data;
               r_valid <= 1'b1;
            end else if (w_pop) begin
               r_main  <= BUBBLE;
               r_valid <= 1'b0;
            end
         end

         assign in_ready  = !r_valid || out_ready;
         assign out_valid = r_valid;
         assign out_data  = r_main;
         assign occupancy = {1'b0, r_valid};
      end
   endgenerate

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (out_valid && !out_ready),
      .clr   (cnt_clr),
      .count (stall_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_elastic_reg
//  Purpose  : Directed self-checking bench for SKID=1 and SKID=0 variants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_elastic_reg;

   logic CLK = 1'b0;
   logic nRST;

   // SKID=1 instance, 16-bit counter
   logic        fl1, v1, r1, clr1;
   logic [31:0] d1;
   logic        rdy1, ov1;
   logic [31:0] od1;
   logic [1:0]  occ1;
   logic [15:0] sc1;

   // SKID=0 instance, 4-bit counter
   logic        fl0, v0, r0, clr0;
   logic [31:0] d0;
   logic        rdy0, ov0;
   logic [31:0] od0;
   logic [1:0]  occ0;
   logic [3:0]  sc0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   pipe_elastic_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut1 (
      .CLK(CLK), .nRST(nRST), .flush(fl1), .in_valid(v1), .in_ready(rdy1),
      .in_data(d1), .out_valid(ov1), .out_ready(r1), .out_data(od1),
      .occupancy(occ1), .stall_cnt(sc1), .cnt_clr(clr1)
   );

   pipe_elastic_reg #(.WIDTH(32), .SKID(0), .CNT_W(4)) dut0 (
      .CLK(CLK), .nRST(nRST), .flush(fl0), .in_valid(v0), .in_ready(rdy0),
      .in_data(d0), .out_valid(ov0), .out_ready(r0), .out_data(od0),
      .occupancy(occ0), .stall_cnt(sc0), .cnt_clr(clr0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      fl1 = 0; v1 = 0; r1 = 0; clr1 = 0; d1 = '0;
      fl0 = 0; v0 = 0; r0 = 0; clr0 = 0; d0 = '0;
      tick();
      tick();

      // Reset state
      chk("rst_ov",   32'(ov1),  0);
      chk("rst_od",   od1,       0);
      chk("rst_rdy",  32'(rdy1), 1);
      chk("rst_occ",  32'(occ1), 0);
      chk("rst_sc",   32'(sc1),  0);
      chk("rst_rdy0", 32'(rdy0), 1);
      #2 nRST = 1'b1;
      tick();

      // Streaming through SKID=1
      r1 = 1; v1 = 1; d1 = 32'h10;
      tick();
      chk("s_od0", od1, 32'h10); chk("s_ov0", 32'(ov1), 1); chk("s_occ0", 32'(occ1), 1);
      d1 = 32'h14;
      tick();
      chk("s_od1", od1, 32'h14); chk("s_ov1", 32'(ov1), 1); chk("s_occ1", 32'(occ1), 1);
      d1 = 32'h18;
      tick();
      chk("s_od2", od1, 32'h18); chk("s_ov2", 32'(ov1), 1); chk("s_occ2", 32'(occ1), 1);
      v1 = 0;
      tick();
      chk("s_drain_ov", 32'(ov1), 0); chk("s_drain_od", od1, 0);

      // Back-pressure fills the skid slot
      r1 = 0; v1 = 1; d1 = 32'hA;
      tick();
      chk("bp_rdy1", 32'(rdy1), 1); chk("bp_occ1", 32'(occ1), 1);
      d1 = 32'hB;
      tick();
      chk("bp_occ2", 32'(occ1), 2); chk("bp_rdy2", 32'(rdy1), 0); chk("bp_od_a", od1, 32'hA);
      d1 = 32'hC;
      tick();
      chk("bp_hold_occ", 32'(occ1), 2); chk("bp_hold_od", od1, 32'hA);
      tick();
      chk("bp_hold_od2", od1, 32'hA); chk("bp_sc", 32'(sc1), 3);
      r1 = 1;
      tick();
      chk("bp_od_b", od1, 32'hB); chk("bp_rdy_back", 32'(rdy1), 1); chk("bp_sc_stop", 32'(sc1), 3);
      tick();
      chk("bp_od_c", od1, 32'hC); chk("bp_occ_c", 32'(occ1), 1);
      v1 = 0;
      tick();
      chk("bp_empty", 32'(ov1), 0);

      // Flush at full occupancy with a simultaneous offer
      r1 = 0; v1 = 1; d1 = 32'h1;
      tick();
      d1 = 32'h2;
      tick();
      chk("fl_pre_occ", 32'(occ1), 2);
      fl1 = 1; d1 = 32'hD;
      tick();
      fl1 = 0; v1 = 0;
      chk("fl_ov", 32'(ov1), 0); chk("fl_od", od1, 0); chk("fl_occ", 32'(occ1), 0);
      chk("fl_rdy", 32'(rdy1), 1); chk("fl_sc_kept", 32'(sc1), 5);
      tick();
      chk("fl_no_d", 32'(ov1), 0); chk("fl_no_d_od", od1, 0);
      clr1 = 1;
      tick();
      clr1 = 0;
      chk("clr_sc1", 32'(sc1), 0);

      // SKID=0: combinational ready and same-cycle pop+accept
      v0 = 1; d0 = 32'h21; r0 = 0;
      tick();
      v0 = 0;
      #1;
      chk("s0_rdy_full", 32'(rdy0), 0); chk("s0_od", od0, 32'h21); chk("s0_occ", 32'(occ0), 1);
      r0 = 1; v0 = 1; d0 = 32'h22;
      #1;
      chk("s0_rdy_comb", 32'(rdy0), 1);
      tick();
      chk("s0_od_next", od0, 32'h22); chk("s0_ov_next", 32'(ov0), 1); chk("s0_sc0", 32'(sc0), 0);

      // Saturation of the 4-bit stall counter
      r0 = 0; v0 = 0;
      repeat (14) tick();
      chk("sat_14", 32'(sc0), 14);
      repeat (6) tick();
      chk("sat_15", 32'(sc0), 15); chk("sat_od_held", od0, 32'h22);
      clr0 = 1;
      tick();
      clr0 = 0;
      chk("sat_clr", 32'(sc0), 0);
      tick();
      chk("sat_resume", 32'(sc0), 1);
      fl0 = 1;
      tick();
      fl0 = 0;
      chk("s0_fl_ov", 32'(ov0), 0); chk("s0_fl_od", od0, 0); chk("s0_fl_rdy", 32'(rdy0), 1);

      // Asynchronous reset in the middle of traffic
      r1 = 0; v1 = 1; d1 = 32'h33;
      tick();
      chk("ar_loaded", od1, 32'h33);
      #2 nRST = 1'b0;
      #1;
      chk("ar_ov", 32'(ov1), 0); chk("ar_od", od1, 0); chk("ar_rdy", 32'(rdy1), 1);
      chk("ar_occ", 32'(occ1), 0); chk("ar_sc0", 32'(sc0), 0);
      v1 = 0;
      tick();
      nRST = 1'b1;
      tick();
      chk("ar_after", 32'(ov1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
